// File: rtl/dm_pkg.sv
// Shared types for the data-memory store buffer: access-type encodings, byte-enable type,
// the buffered store record and the store lane-mapping helpers.
package dm_pkg;

    typedef enum logic [2:0] {
        DM_WORD   = 3'b000,
        DM_HALF   = 3'b001,
        DM_HALF_U = 3'b010,
        DM_BYTE   = 3'b011,
        DM_BYTE_U = 3'b100
    } dm_type_e;

    localparam int unsigned BE_W   = 4;
    localparam int unsigned WA_MAX = 30;

    typedef logic [BE_W-1:0] be_t;

    // Word address is held at full width; the top module compares only its own AW-2 bits
    typedef struct packed {
        logic [WA_MAX-1:0] waddr;
        logic [31:0]       data;
        be_t               be;
    } sb_entry_t;

    function automatic be_t store_be(input logic [2:0] t, input logic [1:0] a);
        case (t)
            DM_HALF, DM_HALF_U: return a[1] ? 4'b1100 : 4'b0011;
            DM_BYTE, DM_BYTE_U: return 4'b0001 << a;
            default:            return '1;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] t, input logic [31:0] d);
        case (t)
            DM_HALF, DM_HALF_U: return {2{d[15:0]}};
            DM_BYTE, DM_BYTE_U: return {4{d[7:0]}};
            default:            return d;
        endcase
    endfunction

endpackage

// File: rtl/dm_store_buffer_if.sv
// Backing-memory side of the store buffer: write-drain handshake and asynchronous read port.
interface dm_store_buffer_if #(
    parameter int unsigned AW = 12
);
    logic          m_wr_req;
    logic [AW-3:0] m_wr_addr;
    logic [31:0]   m_wr_data;
    logic [3:0]    m_wr_be;
    logic          m_wr_ack;
    logic [AW-3:0] m_rd_addr;
    logic [31:0]   m_rd_data;

    modport master (
        output m_wr_req, m_wr_addr, m_wr_data, m_wr_be, m_rd_addr,
        input  m_wr_ack, m_rd_data
    );

    modport slave (
        input  m_wr_req, m_wr_addr, m_wr_data, m_wr_be, m_rd_addr,
        output m_wr_ack, m_rd_data
    );
endinterface

// File: rtl/dm_lane_ext.sv
// Load lane select and sign/zero extension for word, half and byte access types.
module dm_lane_ext
    import dm_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [2:0]  dm_type_i,
    input  logic [1:0]  addr_lo_i,
    output logic [31:0] data_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[8*addr_lo_i +: 8];
        half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
        case (dm_type_i)
            DM_HALF:   data_o = {{16{half_sel[15]}}, half_sel};
            DM_HALF_U: data_o = {16'h0000, half_sel};
            DM_BYTE:   data_o = {{24{byte_sel[7]}}, byte_sel};
            DM_BYTE_U: data_o = {24'h000000, byte_sel};
            default:   data_o = word_i;
        endcase
    end
endmodule

// File: rtl/dm_store_buffer.sv
// FIFO store buffer between the CPU MEM stage and a backing data memory.
// Optional build macro STORE_FWD_EN: loads merge pending stores instead of stalling on a hit.
module dm_store_buffer
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned AW    = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_w,
    input  logic              MemRead,
    input  logic [31:0]       Addr_in,
    input  logic [31:0]       Data_in,
    input  logic [2:0]        DMType,
    output logic [31:0]       Data_out,
    output logic              stall_o,
    output logic              misalign_o,
    output logic              empty_o,
    dm_store_buffer_if.master mem
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    sb_entry_t     ent_q [DEPTH];
    sb_entry_t     ent_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [WA_MAX-1:0] wa;
    logic              full;
    logic              hit;
    logic              push;
    logic              pop;
    logic              load_en;
    logic [31:0]       merged;
    logic [31:0]       ext_in;
    logic [31:0]       ext_out;
    logic              unused_addr_hi;
    int unsigned       idx;

    assign unused_addr_hi = ^Addr_in[31:AW];
    assign wa             = WA_MAX'(Addr_in[AW-1:2]);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        full       = (32'(count_q) == DEPTH);
        empty_o    = (count_q == '0);
        misalign_o = (mem_w | MemRead) &
                     (((DMType == DM_WORD) && (Addr_in[1:0] != 2'b00)) ||
                      (((DMType == DM_HALF) || (DMType == DM_HALF_U)) && Addr_in[0]));

        // Walk occupied slots oldest to newest so younger stores win per byte
        hit    = 1'b0;
        merged = mem.m_rd_data;
        idx    = 0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = 32'(head_q) + k;
            if (idx >= DEPTH) idx = idx - DEPTH;
            if ((k < 32'(count_q)) && (ent_q[PW'(idx)].waddr == wa)) begin
                hit = 1'b1;
                for (int unsigned b = 0; b < BE_W; b++) begin
                    if (ent_q[PW'(idx)].be[b]) merged[8*b +: 8] = ent_q[PW'(idx)].data[8*b +: 8];
                end
            end
        end

`ifdef STORE_FWD_EN
        stall_o = mem_w & full;
        ext_in  = merged;
`else
        stall_o = (mem_w & full) | (MemRead & ~mem_w & hit);
        ext_in  = mem.m_rd_data;
`endif

        load_en = MemRead & ~mem_w & ~misalign_o;
        push    = mem_w & ~misalign_o & ~full;
        pop     = ~empty_o & mem.m_wr_ack;
    end

`ifdef STORE_FWD_EN
    logic unused_hit;
    assign unused_hit = hit;
`else
    logic unused_merged;
    assign unused_merged = ^merged;
`endif

    always_comb begin
        ent_d   = ent_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            ent_d[tail_q] = '{waddr: wa,
                              data:  store_data(DMType, Data_in),
                              be:    store_be(DMType, Addr_in[1:0])};
            tail_d = ptr_inc(tail_q);
        end
        if (pop) head_d = ptr_inc(head_q);
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_q   <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            ent_q   <= ent_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    dm_lane_ext u_lane_ext (
        .word_i    (ext_in),
        .dm_type_i (DMType),
        .addr_lo_i (Addr_in[1:0]),
        .data_o    (ext_out)
    );

    assign Data_out      = load_en ? ext_out : '0;
    assign mem.m_wr_req  = ~empty_o;
    assign mem.m_wr_addr = ent_q[head_q].waddr[AW-3:0];
    assign mem.m_wr_data = ent_q[head_q].data;
    assign mem.m_wr_be   = ent_q[head_q].be;
    assign mem.m_rd_addr = Addr_in[AW-1:2];
endmodule

// File: tb/tb_dm_store_buffer.sv
// Self-checking bench for dm_store_buffer: directed scenarios plus random traffic against
// a queue-based model of the buffer and a word-array model of the backing memory.
module tb_dm_store_buffer;
    import dm_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned AW    = 12;
    localparam int unsigned NW    = 1 << (AW - 2);

    typedef struct packed {
        logic [AW-3:0] wa;
        logic [31:0]   data;
        logic [3:0]    be;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_w;
    logic        MemRead;
    logic [31:0] Addr_in;
    logic [31:0] Data_in;
    logic [2:0]  DMType;
    logic [31:0] Data_out;
    logic        stall_o;
    logic        misalign_o;
    logic        empty_o;
    logic        ack;

    logic [31:0] mem_model [NW];
    ent_t        q [$];
    int          checks;
    int          errors;

    dm_store_buffer_if #(.AW(AW)) mif ();

    assign mif.m_wr_ack  = ack;
    assign mif.m_rd_data = mem_model[Addr_in[AW-1:2]];

    dm_store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_w      (mem_w),
        .MemRead    (MemRead),
        .Addr_in    (Addr_in),
        .Data_in    (Data_in),
        .DMType     (DMType),
        .Data_out   (Data_out),
        .stall_o    (stall_o),
        .misalign_o (misalign_o),
        .empty_o    (empty_o),
        .mem        (mif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic model_mis(input logic w, input logic r, input logic [31:0] a,
                                       input logic [2:0] t);
        if (!(w || r)) return 1'b0;
        if (t == 3'd0) return a[1:0] != 2'b00;
        if (t == 3'd1 || t == 3'd2) return a[0];
        return 1'b0;
    endfunction

    function automatic ent_t mk_ent(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
        ent_t e;
        e.wa = a[AW-1:2];
        case (t)
            3'd1, 3'd2: begin e.be = a[1] ? 4'b1100 : 4'b0011; e.data = {d[15:0], d[15:0]}; end
            3'd3, 3'd4: begin e.be = 4'(1 << a[1:0]); e.data = {4{d[7:0]}}; end
            default:    begin e.be = 4'b1111; e.data = d; end
        endcase
        return e;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [2:0] t);
        logic [31:0] w;
        logic [15:0] h;
        logic [7:0]  b8;
        w = mem_model[a[AW-1:2]];
`ifdef STORE_FWD_EN
        for (int i = 0; i < q.size(); i++)
            if (q[i].wa == a[AW-1:2])
                for (int b = 0; b < 4; b++)
                    if (q[i].be[b]) w[8*b +: 8] = q[i].data[8*b +: 8];
`endif
        h  = 16'(w >> (16 * a[1]));
        b8 = 8'(w >> (8 * a[1:0]));
        case (t)
            3'd1:    return 32'($signed(h));
            3'd2:    return 32'(h);
            3'd3:    return 32'($signed(b8));
            3'd4:    return 32'(b8);
            default: return w;
        endcase
    endfunction

    task automatic check_outputs();
        logic mis, full, match, ld_stall;
        full  = (q.size() == DEPTH);
        mis   = model_mis(mem_w, MemRead, Addr_in, DMType);
        match = 1'b0;
        foreach (q[i]) if (q[i].wa == Addr_in[AW-1:2]) match = 1'b1;
`ifdef STORE_FWD_EN
        ld_stall = 1'b0;
`else
        ld_stall = MemRead && !mem_w && match;
`endif
        chk("misalign", misalign_o, mis);
        chk("stall", stall_o, (mem_w && full) || ld_stall);
        chk("empty", empty_o, q.size() == 0);
        chk("m_wr_req", mif.m_wr_req, q.size() != 0);
        chk("m_rd_addr", mif.m_rd_addr, Addr_in[AW-1:2]);
        if (q.size() != 0) begin
            chk("m_wr_addr", mif.m_wr_addr, q[0].wa);
            chk("m_wr_data", mif.m_wr_data, q[0].data);
            chk("m_wr_be", mif.m_wr_be, q[0].be);
        end
        if (!ld_stall)
            chk("Data_out", Data_out,
                (MemRead && !mem_w && !mis) ? exp_load(Addr_in, DMType) : 32'h0);
    endtask

    task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] t, input logic k);
        mem_w = w; MemRead = r; Addr_in = a; Data_in = d; DMType = t; ack = k;
        #1;
        check_outputs();
    endtask

    task automatic tick();
        logic push, pop;
        ent_t e;
        push = mem_w && !model_mis(mem_w, MemRead, Addr_in, DMType) && (q.size() < DEPTH);
        pop  = (q.size() != 0) && ack;
        e    = mk_ent(Addr_in, Data_in, DMType);
        @(posedge clk);
        if (pop) begin
            for (int b = 0; b < 4; b++)
                if (q[0].be[b]) mem_model[q[0].wa][8*b +: 8] = q[0].data[8*b +: 8];
            void'(q.pop_front());
        end
        if (push) q.push_back(e);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b1);
            tick();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        foreach (mem_model[i]) mem_model[i] = $urandom;
        q.delete();

        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
        chk("rst_empty", empty_o, 1'b1);
        chk("rst_req", mif.m_wr_req, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // sb 0xA5 at byte address 1
        drive(1'b1, 1'b0, 32'h001, 32'h000000A5, 3'd3, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
        chk("sb_req", mif.m_wr_req, 1'b1);
        chk("sb_addr", mif.m_wr_addr, 32'h0);
        chk("sb_be", mif.m_wr_be, 32'h2);
        chk("sb_data", mif.m_wr_data, 32'hA5A5A5A5);
        tick();
        drain();

        // Fill with acks held low, then release one ack
        drive(1'b1, 1'b0, 32'h010, $urandom, 3'd0, 1'b0); tick();
        drive(1'b1, 1'b0, 32'h014, $urandom, 3'd0, 1'b0); tick();
        drive(1'b1, 1'b0, 32'h018, 32'hCAFE0018, 3'd0, 1'b0);
        chk("full_stall", stall_o, 1'b1);
        tick();
        drive(1'b1, 1'b0, 32'h018, 32'hCAFE0018, 3'd0, 1'b1);
        chk("full_pop_stall", stall_o, 1'b1);
        tick();
        drive(1'b1, 1'b0, 32'h018, 32'hCAFE0018, 3'd0, 1'b0);
        chk("after_pop_stall", stall_o, 1'b0);
        tick();
        drain();

        // Half store then half loads of the same word
        mem_model[32'h102 >> 2] = 32'h11223344;
        drive(1'b1, 1'b0, 32'h102, 32'h00008001, 3'd1, 1'b0); tick();
        drive(1'b0, 1'b1, 32'h102, 32'h0, 3'd1, 1'b0);
`ifdef STORE_FWD_EN
        chk("fwd_lh", Data_out, 32'hFFFF8001);
        chk("fwd_lh_stall", stall_o, 1'b0);
        tick();
        drive(1'b0, 1'b1, 32'h102, 32'h0, 3'd2, 1'b0);
        chk("fwd_lhu", Data_out, 32'h00008001);
        tick();
`else
        chk("hit_stall", stall_o, 1'b1);
        tick();
        drive(1'b0, 1'b1, 32'h102, 32'h0, 3'd1, 1'b1);
        chk("hit_stall_ack", stall_o, 1'b1);
        tick();
        drive(1'b0, 1'b1, 32'h102, 32'h0, 3'd1, 1'b0);
        chk("post_lh_stall", stall_o, 1'b0);
        chk("post_lh", Data_out, 32'hFFFF8001);
        tick();
        drive(1'b0, 1'b1, 32'h102, 32'h0, 3'd2, 1'b0);
        chk("post_lhu", Data_out, 32'h00008001);
        tick();
`endif
        drain();

        // Misaligned word load and store
        drive(1'b0, 1'b1, 32'h006, 32'h0, 3'd0, 1'b0);
        chk("mis_lw_flag", misalign_o, 1'b1);
        chk("mis_lw_data", Data_out, 32'h0);
        tick();
        drive(1'b1, 1'b0, 32'h006, 32'h12345678, 3'd0, 1'b0);
        chk("mis_sw_flag", misalign_o, 1'b1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
        chk("mis_sw_empty", empty_o, 1'b1);
        tick();

        // Random traffic over a small address window to exercise forwarding and wrap
        repeat (400) begin
            logic [31:0] a;
            a = 32'(($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
            drive(($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0), a, $urandom,
                  3'($urandom_range(0, 4)), ($urandom_range(0, 2) != 0));
            tick();
        end
        drain();

        // Reset with two pending entries
        drive(1'b1, 1'b0, 32'h020, $urandom, 3'd0, 1'b0); tick();
        drive(1'b1, 1'b0, 32'h024, $urandom, 3'd0, 1'b0); tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
        chk("pre_rst_req", mif.m_wr_req, 1'b1);
        rst = 1'b0;
        #1;
        q.delete();
        chk("in_rst_req", mif.m_wr_req, 1'b0);
        chk("in_rst_empty", empty_o, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b1);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dm_store_buffer.md
DM_STORE_BUFFER -- requirements
Module: dm_store_buffer

Interface
REQ-001 Parameter DEPTH, default 2, meaning number of store-buffer entries (legal values 1..8).
REQ-002 Parameter AW, default 12, meaning backing-memory byte-address width; the word address is AW-2 bits wide.
REQ-003 clk  input  1  sole clock; all state is updated on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 mem_w  input  1  CPU store request in the MEM stage.
REQ-006 MemRead  input  1  CPU load request in the MEM stage.
REQ-007 Addr_in  input  32  CPU byte address; only bits [AW-1:0] are used.
REQ-008 Data_in  input  32  CPU store data, right-aligned.
REQ-009 DMType  input  3  access type: 000 word, 001 half, 010 half-unsigned, 011 byte, 100 byte-unsigned.
REQ-010 Data_out  output  32  load result, aligned and extended, combinational.
REQ-011 stall_o  output  1  CPU must hold its MEM-stage access this cycle.
REQ-012 misalign_o  output  1  current access is misaligned.
REQ-013 empty_o  output  1  store buffer holds no entries.
REQ-014 m_wr_req  output  1  backing-memory write request (head entry).
REQ-015 m_wr_addr  output  AW-2  head entry word address.
REQ-016 m_wr_data  output  32  head entry lane-replicated data.
REQ-017 m_wr_be  output  4  head entry byte enables.
REQ-018 m_wr_ack  input  1  backing memory accepts the head entry this cycle.
REQ-019 m_rd_addr  output  AW-2  asynchronous read word address, equal to Addr_in[AW-1:2].
REQ-020 m_rd_data  input  32  asynchronous read data.

Function
REQ-021 Store lane mapping: word gives be=1111 and data unchanged; half gives be=0011<<(2*Addr_in[1]) and data {2{Data_in[15:0]}}; byte gives be=0001<<Addr_in[1:0] and data {4{Data_in[7:0]}}.
REQ-022 Misalignment: misalign_o=1 when a word access has Addr_in[1:0]!=0, or a half access has Addr_in[0]=1; it is asserted only while mem_w or MemRead is 1.
REQ-023 A misaligned store is discarded and not enqueued; a misaligned load returns Data_out=0.
REQ-024 A store is enqueued on the rising edge when mem_w=1, misalign_o=0 and stall_o=0; each entry holds {word address, data, be}.
REQ-025 Buffer is a FIFO with an occupancy count from 0 to DEPTH; wrap-around of the head and tail pointers is modulo DEPTH.
REQ-026 m_wr_req equals !empty_o; the head entry is popped on a cycle with m_wr_req=1 and m_wr_ack=1; m_wr_* stay stable while m_wr_req=1 and m_wr_ack=0.
REQ-027 stall_o=1 when mem_w=1 and the count equals DEPTH, even if a pop occurs in the same cycle; the store is accepted on the first cycle after the count drops below DEPTH.
REQ-028 A simultaneous push and pop with the count below DEPTH leaves the count unchanged.
REQ-029 If mem_w=1 and MemRead=1 together, the access is treated as a store and Data_out=0.
REQ-030 Load path: take m_rd_data and overlay, per byte, every valid entry whose word address equals Addr_in[AW-1:2], applied oldest to newest; then select the lane and extend it.
REQ-031 Extension: byte/half types are sign-extended, the unsigned types zero-extended; lane is chosen by Addr_in[1:0] for bytes and Addr_in[1] for halves.
REQ-032 Data_out=0 whenever MemRead=0.
REQ-033 Load latency is 0 cycles; store-to-memory latency is at least 1 cycle after enqueue.

Reset
REQ-034 While rst=0: count=0, pointers=0, entries invalid, m_wr_req=0, stall_o=0, empty_o=1; Data_out and misalign_o follow their combinational rules.
REQ-035 Reset during a pending drain discards every entry; no further m_wr_req is raised for those entries after rst returns to 1.

Configuration
REQ-036 With STORE_FWD_EN defined, loads use the byte-merge forwarding of REQ-030.
REQ-037 Without STORE_FWD_EN, a load whose word address matches any valid entry asserts stall_o=1 until no such entry remains; only then does Data_out use m_rd_data alone.

Structure
REQ-038 The DMType encodings, byte-enable widths and entry-record typedef reside in the shared package dm_pkg.
REQ-039 One sub-module, dm_lane_ext, performs the combinational lane select and sign/zero extension.

Verification
REQ-040 Reset, then sb at Addr 0x001 with Data 0x000000A5 -> next cycle m_wr_req=1, m_wr_addr=0, m_wr_be=0010, m_wr_data=0xA5A5A5A5.
REQ-041 m_wr_ack held 0, three word stores at DEPTH=2 -> third store has stall_o=1; after one ack it is accepted on the next edge.
REQ-042 STORE_FWD_EN defined, sh 0x8001 at 0x102, ack low, m_rd_data=0x11223344, lh at 0x102 -> Data_out=0xFFFF8001; lhu -> 0x00008001.
REQ-043 STORE_FWD_EN undefined, same sequence -> stall_o=1 until ack; then lh returns the m_rd_data-based value.
REQ-044 lw at 0x006 -> misalign_o=1, Data_out=0; sw at 0x006 -> nothing enqueued, empty_o stays 1.
REQ-045 Two stores enqueued, rst pulsed low for 1 cycle -> m_wr_req=0 and empty_o=1 afterwards, with no write issued.
